// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: controller states and port ids.
package data_mem_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);

    assign gnt_vld_o = req0_i | req1_i;
    assign gnt_id_o  = (req0_i && req1_i) ? ((last_i == PORT_AUX) ? PORT_CPU : PORT_AUX)
                                          : (req1_i ? PORT_AUX : PORT_CPU);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one stalling data memory between the CPU port and an auxiliary
// (DMA/debug) port, one transaction at a time.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_sign_mask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_sign_mask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [MASK_W-1:0] mem_sign_mask,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall,
    output logic              grant_id,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic              arb_vld, arb_id;

    rr_arbiter2 u_arb (
        .req0_i    (p0_req),
        .req1_i    (p1_req),
        .last_i    (last_q),
        .gnt_vld_o (arb_vld),
        .gnt_id_o  (arb_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= PORT_CPU;
            last_q  <= PORT_AUX;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                // A stalled memory may still be finishing an access abandoned by reset.
                if (!mem_clk_stall && arb_vld) begin
                    gnt_d   = arb_id;
                    state_d = ISSUE;
                    if (arb_id == PORT_AUX) begin
                        we_d    = p1_we;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                        mask_d  = p1_sign_mask;
                    end else begin
                        we_d    = p0_we;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                        mask_d  = p0_sign_mask;
                    end
                end
            end
            ISSUE:   state_d = WAIT_HI;
            WAIT_HI: if (mem_clk_stall) state_d = WAIT_LO;
            WAIT_LO: begin
                if (!mem_clk_stall) begin
                    if (!we_q) begin
                        if (gnt_q == PORT_AUX) rd1_d = mem_read_data;
                        else                   rd0_d = mem_read_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = mask_q;
    assign mem_memread    = (state_q == ISSUE) && !we_q;
    assign mem_memwrite   = (state_q == ISSUE) &&  we_q;
    assign p0_ack         = (state_q == DONE) && (gnt_q == PORT_CPU);
    assign p1_ack         = (state_q == DONE) && (gnt_q == PORT_AUX);
    assign p0_rdata       = rd0_q;
    assign p1_rdata       = rd1_q;
    assign grant_id       = gnt_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a two-cycle-stall memory model and
// an in-order transaction scoreboard.
module tb_data_mem_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0;
    logic [3:0]  p0_sign_mask = '0;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [31:0] p1_addr = '0, p1_wdata = '0;
    logic [3:0]  p1_sign_mask = '0;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite, mem_clk_stall;
    logic        grant_id, busy;

    logic        stall_q = 1'b0;
    logic        force_stall = 1'b0;
    int          cnt_q = 0;
    logic [31:0] lat_addr_q = '0;
    logic [31:0] rd_q = '0;

    txn_t        sb[$];
    logic [31:0] exp_rd [2];
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_mask;
    logic        in_flight = 1'b0, prev_strobe = 1'b0, strobe;
    logic        auto_drop = 1'b1;
    int          cyc = 0, last_ack_cyc = 0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory: stalls for two cycles after a strobe, read data valid as stall drops.
    assign mem_clk_stall = stall_q | force_stall;
    assign mem_read_data = rd_q;
    always @(posedge clk) begin
        if (mem_memread | mem_memwrite) begin
            stall_q    <= 1'b1;
            cnt_q      <= 2;
            lat_addr_q <= mem_addr;
            rd_q       <= 32'h0BAD0BAD;
        end else if (cnt_q > 1) begin
            cnt_q <= cnt_q - 1;
        end else if (cnt_q == 1) begin
            cnt_q   <= 0;
            stall_q <= 1'b0;
            rd_q    <= memfn(lat_addr_q);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_sign_mask = mask; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_sign_mask = mask; p0_req = 1'b1;
        end
    endtask

    task automatic push(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        txn_t t;
        t.port = port; t.we = we; t.addr = addr; t.wdata = wdata; t.mask = mask;
        sb.push_back(t);
    endtask

    task automatic step();
        txn_t t;
        @(negedge clk);
        cyc++;
        chk("ack_onehot", {31'b0, p0_ack & p1_ack}, 32'd0);
        chk("strobe_excl", {31'b0, mem_memread & mem_memwrite}, 32'd0);
        strobe = mem_memread | mem_memwrite;
        if (strobe) begin
            chk("strobe_1cyc", {31'b0, prev_strobe}, 32'd0);
            if (sb.size() == 0) begin
                chk("strobe_unexpected", {31'b0, strobe}, 32'd0);
            end else begin
                chk("mem_addr", mem_addr, sb[0].addr);
                chk("mem_wdata", mem_write_data, sb[0].wdata);
                chk("mem_mask", {28'b0, mem_sign_mask}, {28'b0, sb[0].mask});
                chk("strobe_type", {31'b0, mem_memwrite}, {31'b0, sb[0].we});
                chk("grant_id", {31'b0, grant_id}, {31'b0, sb[0].port});
                chk("busy_issue", {31'b0, busy}, 32'd1);
                hold_addr = mem_addr; hold_wdata = mem_write_data; hold_mask = mem_sign_mask;
                in_flight = 1'b1;
            end
        end else if (in_flight && !rst) begin
            chk("hold_addr", mem_addr, hold_addr);
            chk("hold_wdata", mem_write_data, hold_wdata);
            chk("hold_mask", {28'b0, mem_sign_mask}, {28'b0, hold_mask});
        end
        if (p0_ack | p1_ack) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", {31'b0, p0_ack | p1_ack}, 32'd0);
            end else begin
                t = sb.pop_front();
                chk("ack_port", {31'b0, p1_ack}, {31'b0, t.port});
                if (!t.we) exp_rd[t.port] = memfn(t.addr);
                chk("p0_rdata", p0_rdata, exp_rd[0]);
                chk("p1_rdata", p1_rdata, exp_rd[1]);
                in_flight = 1'b0;
                last_ack_cyc = cyc;
                if (auto_drop) begin
                    if (t.port) p1_req = 1'b0;
                    else        p0_req = 1'b0;
                end
            end
        end
        prev_strobe = strobe;
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            step();
            n++;
        end while (!(p0_ack | p1_ack) && n < 50);
        chk("ack_timeout", {31'b0, p0_ack | p1_ack}, 32'd1);
    endtask

    initial begin
        int c0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        // Reset state
        step(); step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
        chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_p1_rdata", p1_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_mask", {28'b0, mem_sign_mask}, 32'd0);

        // Tie straight after reset: port 0 first, port 1 one transaction later
        rst = 1'b0;
        push(1'b0, 1'b0, 32'h140, 32'h0, 4'h2);
        push(1'b1, 1'b0, 32'h180, 32'h0, 4'h2);
        drive(1'b0, 1'b0, 32'h140, 32'h0, 4'h2);
        drive(1'b1, 1'b0, 32'h180, 32'h0, 4'h2);
        wait_ack();
        c0 = last_ack_cyc;
        wait_ack();
        chk("tie_gap", last_ack_cyc - c0, 32'd6);

        // Both ports held for six transactions: grants alternate 0,1,0,1,0,1
        auto_drop = 1'b0;
        for (int i = 0; i < 6; i++) push(i[0], 1'b0, i[0] ? 32'h204 : 32'h200, 32'h0, 4'h2);
        drive(1'b0, 1'b0, 32'h200, 32'h0, 4'h2);
        drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h2);
        repeat (6) wait_ack();
        p0_req = 1'b0;
        p1_req = 1'b0;
        auto_drop = 1'b1;
        chk("alt_sb_empty", sb.size(), 32'd0);

        // Single p0 read of 0x100: ack five cycles after the request is taken
        step();
        push(1'b0, 1'b0, 32'h100, 32'h0, 4'h2);
        drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h2);
        c0 = cyc;
        wait_ack();
        chk("latency", cyc - c0, 32'd5);
        chk("p0_deadbeef", p0_rdata, 32'hDEADBEEF);

        // p1 write to the LED address; p1_rdata must not move
        step();
        push(1'b1, 1'b1, 32'h2000, 32'h55, 4'h4);
        drive(1'b1, 1'b1, 32'h2000, 32'h55, 4'h4);
        wait_ack();
        chk("p1_rdata_kept", p1_rdata, memfn(32'h204));

        // Request withdrawn before grant is never served
        step();
        force_stall = 1'b1;
        drive(1'b1, 1'b0, 32'h400, 32'h0, 4'h1);
        repeat (3) step();
        chk("no_grant_stalled", {31'b0, busy}, 32'd0);
        p1_req = 1'b0;
        force_stall = 1'b0;
        repeat (3) step();
        chk("dropped_ignored", {31'b0, busy}, 32'd0);

        // Reset in WAIT_LO while memory keeps stalling
        push(1'b0, 1'b0, 32'h300, 32'h0, 4'h2);
        drive(1'b0, 1'b0, 32'h300, 32'h0, 4'h2);
        repeat (3) step();
        chk("in_wait_lo", {31'b0, busy & mem_clk_stall}, 32'd1);
        in_flight = 1'b0;
        rst = 1'b1;
        force_stall = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_p0_rdata", p0_rdata, 32'd0);
        chk("rst_mid_p1_rdata", p1_rdata, 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_quiet", {28'b0, p0_ack, p1_ack, mem_memread, mem_memwrite}, 32'd0);
        end
        push(1'b0, 1'b0, 32'h300, 32'h0, 4'h2);
        force_stall = 1'b0;
        wait_ack();
        chk("post_rst_rdata", p0_rdata, memfn(32'h300));
        step();
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; MASK_W, 4, sign_mask width.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: ports clk, rst.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 p0_req  in  1  port-0 (CPU) request; held high until p0_ack.
REQ-006 p0_we  in  1  1=write, 0=read; stable while p0_req is high.
REQ-007 p0_addr  in  ADDR_W  byte address; stable while p0_req is high.
REQ-008 p0_wdata  in  DATA_W  store data; p0_sign_mask  in  MASK_W  load/store size and sign code, passed through unchanged.
REQ-009 p0_ack  out  1  one-cycle completion pulse; p0_rdata  out  DATA_W  load data, valid when p0_ack=1.
REQ-010 p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask, p1_ack, p1_rdata: port 1 (DMA/debug), same widths and meanings as port 0.
REQ-011 mem_addr  out  ADDR_W; mem_write_data  out  DATA_W; mem_sign_mask  out  MASK_W: muxed memory request.
REQ-012 mem_memread, mem_memwrite  out  1  one-cycle request strobes to data memory.
REQ-013 mem_read_data  in  DATA_W; mem_clk_stall  in  1  memory busy flag.
REQ-014 grant_id  out  1  port currently owning memory (debug), valid while busy=1; busy  out  1  transaction in flight.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-016 IDLE: if mem_clk_stall=0 and any req=1, latch winner, its addr/wdata/we/sign_mask into registers -> ISSUE; otherwise stay.
REQ-017 Arbitration SHALL be two-way round-robin: single requester wins; if both request, the port not served last wins; last-served pointer resets to port 1, so port 0 wins the first tie.
REQ-018 ISSUE: drive latched request on mem_*, assert exactly one of mem_memread/mem_memwrite for this cycle only -> WAIT_HI.
REQ-019 WAIT_HI: stay until mem_clk_stall=1 -> WAIT_LO.
REQ-020 WAIT_LO: stay until mem_clk_stall=0; on that cycle register mem_read_data into the winner's rdata register -> DONE.
REQ-021 DONE: pulse winner's ack for exactly one cycle, update last-served pointer -> IDLE.
REQ-022 mem_addr, mem_write_data, mem_sign_mask SHALL hold latched values from ISSUE through DONE; strobes SHALL be 0 outside ISSUE.
REQ-023 Nominal latency against a memory that stalls 2 cycles: req seen in IDLE at edge N, ack high in cycle N+5.
REQ-024 pN_rdata SHALL hold its value until that port's next read completes; writes SHALL NOT update rdata.
REQ-025 Loser's request SHALL remain pending and be granted in the next IDLE; worst-case wait is one transaction.
REQ-026 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL still complete and pulse ack (protocol violation, defined behaviour).
REQ-027 Never more than one ack high per cycle; never both strobes high.
REQ-028 Address 0x2000 (LED) SHALL be forwarded like any other write; no address decoding in this block.

Reset
REQ-029 rst at any edge, including mid-transaction, SHALL force IDLE; ack, strobes, busy to 0; rdata, mem_addr, mem_write_data, mem_sign_mask to 0; pointer to port 1.
REQ-030 After reset, no new ISSUE until mem_clk_stall=0 (memory has no reset and may be finishing an abandoned access).

Structure
REQ-031 State encoding and port-id constants (PORT_CPU=0, PORT_AUX=1) SHALL live in the shared processor package.
REQ-032 Winner selection SHALL be a sub-module rr_arbiter2 (inputs: two reqs, last pointer; outputs: grant valid, grant id), purely combinational.

Verification
REQ-033 p0 read addr 0x100 only; memory stalls 2 cycles, returns 0xDEADBEEF -> one mem_memread pulse, p0_ack at N+5, p0_rdata=0xDEADBEEF.
REQ-034 p0 and p1 request same cycle after reset -> p0 served first, p1 next; p1_ack exactly one transaction after p0_ack.
REQ-035 Both ports hold req continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-036 p1 write 0x2000 data 0x55 sign_mask 0x4 -> mem_memwrite one cycle with addr 0x2000, data 0x55, mask 0x4; p1_ack pulses; p1_rdata unchanged.
REQ-037 rst asserted in WAIT_LO with mem_clk_stall held 1 for 3 more cycles -> no ack, no strobe until mem_clk_stall=0, then pending req issues normally.
REQ-038 Assertions throughout: strobes mutually exclusive and single-cycle, acks one-hot-or-zero, mem_* stable ISSUE..DONE.
